// File: rtl/nn_bus_pkg.sv
// ============================================================================
// Module : nn_bus_pkg
// Brief  : Shared widths, command record and holding-state encoding for the NN bus master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nn_bus_pkg;

  localparam int   NN_ADDR_W   = 20;
  localparam int   NN_DATA_W   = 32;
  localparam logic NN_RW_WRITE = 1'b1;

  typedef struct packed {
    logic                 rw;
    logic [NN_ADDR_W-1:0] addr;
    logic [NN_DATA_W-1:0] data;
  } nn_cmd_t;

  typedef enum logic [0:0] {
    HOLD_EMPTY = 1'b0,
    HOLD_HELD  = 1'b1
  } hold_state_t;

endpackage

`default_nettype wire

// File: rtl/nn_bus_master_if.sv
// ============================================================================
// Module : nn_bus_master_if
// Brief  : Command stream, NN transfer bus and response stream of the NN bus master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface nn_bus_master_if;
  import nn_bus_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_rw;
  logic [NN_ADDR_W-1:0] cmd_addr;
  logic [NN_DATA_W-1:0] cmd_data;

  logic                 RW;
  logic                 sel;
  logic [NN_ADDR_W-1:0] addr;
  logic [NN_DATA_W-1:0] din;
  logic [NN_DATA_W-1:0] dout;
  logic                 bus_stop;
  logic                 pushout;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [NN_DATA_W-1:0] rsp_data;
  logic                 err_spurious;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_data, dout, bus_stop, pushout, rsp_ready,
    output cmd_ready, RW, sel, addr, din, rsp_valid, rsp_data, err_spurious
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_data, dout, bus_stop, pushout, rsp_ready,
    input  cmd_ready, RW, sel, addr, din, rsp_valid, rsp_data, err_spurious
  );

endinterface

`default_nettype wire

// File: rtl/nn_rsp_fifo.sv
// ============================================================================
// Module : nn_rsp_fifo
// Brief  : Synchronous power-of-two FIFO with occupancy count; head reads as zero when empty.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nn_rsp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] head,
  output logic                  valid,
  output logic      [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = pop && (r_count != '0);
  assign w_push = push && ((r_count != FULL_CNT) || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Gate the head so a flushed FIFO presents zero instead of stale storage.
  assign valid = (r_count != '0);
  assign head  = valid ? r_mem[r_rd_ptr] : '0;
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/nn_bus_master.sv
// ============================================================================
// Module : nn_bus_master
// Brief  : Issues queued commands as sel transfers to the NN block; credit-gated reads.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nn_bus_master
  import nn_bus_pkg::*;
#(
  parameter int RSP_DEPTH = 4
) (
  input wire logic        clk,
  input wire logic        reset,
  nn_bus_master_if.master bus
);

  localparam int               CNT_W        = $clog2(RSP_DEPTH) + 1;
  localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W + 1)'(RSP_DEPTH);

  hold_state_t      r_state;
  hold_state_t      w_state_nxt;
  nn_cmd_t          r_cmd;
  logic [CNT_W-1:0] r_outstanding;
  logic             r_err;
  logic [CNT_W-1:0] w_rsp_count;
  logic [CNT_W:0]   w_credit_sum;
  logic             w_credit_ok;
  logic             w_sel;
  logic             w_accept;
  logic             w_cmd_ready;
  logic             w_take;
  logic             w_rd_issue;
  logic             w_rd_return;
  logic             w_spurious;
  logic             w_rsp_pop;

  // Credit counts both queued responses and reads still in flight, so a return always fits.
  assign w_credit_sum = {1'b0, w_rsp_count} + {1'b0, r_outstanding};
  assign w_credit_ok  = (w_credit_sum < CREDIT_LIMIT);
  assign w_sel        = (r_state == HOLD_HELD) && ((r_cmd.rw == NN_RW_WRITE) || w_credit_ok);
  assign w_accept     = w_sel && !bus.bus_stop;
  assign w_cmd_ready  = (r_state == HOLD_EMPTY) || w_accept;
  assign w_take       = bus.cmd_valid && w_cmd_ready;
  assign w_rd_issue   = w_accept && (r_cmd.rw != NN_RW_WRITE);
  assign w_rd_return  = bus.pushout && (r_outstanding != '0);
  assign w_spurious   = bus.pushout && (r_outstanding == '0);
  assign w_rsp_pop    = bus.rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= HOLD_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HOLD_EMPTY: if (w_take) w_state_nxt = HOLD_HELD;
      HOLD_HELD:  if (w_accept && !w_take) w_state_nxt = HOLD_EMPTY;
      default:    w_state_nxt = HOLD_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd <= '0;
    end else if (w_take) begin
      r_cmd <= {bus.cmd_rw, bus.cmd_addr, bus.cmd_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      case ({w_rd_issue, w_rd_return})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_spurious) r_err <= 1'b1;
    end
  end

  nn_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (NN_DATA_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_rd_return),
    .push_data (bus.dout),
    .pop       (w_rsp_pop),
    .head      (bus.rsp_data),
    .valid     (bus.rsp_valid),
    .count     (w_rsp_count)
  );

  assign bus.sel          = w_sel;
  assign bus.RW           = r_cmd.rw;
  assign bus.addr         = r_cmd.addr;
  assign bus.din          = r_cmd.data;
  assign bus.cmd_ready    = w_cmd_ready;
  assign bus.err_spurious = r_err;

endmodule

`default_nettype wire

// File: tb/tb_nn_bus_master.sv
// ============================================================================
// Module : tb_nn_bus_master
// Brief  : Directed and randomized checks of nn_bus_master against a queue-based reference.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nn_bus_master;
  import nn_bus_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nn_bus_master_if bus ();

  nn_bus_master #(.RSP_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: one pending command slot, a count of reads in flight, a queue of responses.
  bit          m_held;
  logic        m_rw;
  logic [19:0] m_addr;
  logic [31:0] m_data;
  int          m_out;
  logic [31:0] m_q[$];
  bit          m_err;
  bit          last_take;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_sel();
    return m_held && (m_rw || ((m_q.size() + m_out) < DEPTH));
  endfunction

  task automatic model_clear();
    m_held = 0; m_rw = 0; m_addr = '0; m_data = '0;
    m_out = 0; m_q.delete(); m_err = 0; last_take = 0;
  endtask

  task automatic compare_all();
    bit s;
    s = exp_sel();
    check("sel", bus.sel, s);
    check("RW", bus.RW, m_rw);
    check("addr", bus.addr, m_addr);
    check("din", bus.din, m_data);
    check("cmd_ready", bus.cmd_ready, !m_held || (s && !bus.bus_stop));
    check("rsp_valid", bus.rsp_valid, m_q.size() > 0);
    check("rsp_data", bus.rsp_data, (m_q.size() > 0) ? m_q[0] : 32'h0);
    check("err_spurious", bus.err_spurious, m_err);
  endtask

  task automatic model_update();
    bit s, acc, rdy, take, pushok;
    s      = exp_sel();
    acc    = s && !bus.bus_stop;
    rdy    = !m_held || acc;
    take   = bus.cmd_valid && rdy;
    pushok = bus.pushout && (m_out > 0);
    if (bus.pushout && m_out == 0) m_err = 1;
    if (m_q.size() > 0 && bus.rsp_ready) void'(m_q.pop_front());
    if (pushok) m_q.push_back(bus.dout);
    m_out = m_out + ((acc && !m_rw) ? 1 : 0) - (pushok ? 1 : 0);
    if (take) begin
      m_held = 1; m_rw = bus.cmd_rw; m_addr = bus.cmd_addr; m_data = bus.cmd_data;
    end else if (acc) begin
      m_held = 0;
    end
    last_take = take;
  endtask

  task automatic idle();
    bus.cmd_valid = 0; bus.cmd_rw = 0; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.dout = '0; bus.bus_stop = 0; bus.pushout = 0; bus.rsp_ready = 0;
  endtask

  // One cycle: check outputs mid-cycle, then advance the reference at the edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic reset_on();
    reset = 0;
    model_clear();
    #1;
  endtask

  task automatic reset_off();
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic send_cmd(input logic rw, input logic [19:0] a, input logic [31:0] d);
    bus.cmd_valid = 1; bus.cmd_rw = rw; bus.cmd_addr = a; bus.cmd_data = d;
  endtask

  initial begin
    int taken;
    int guard;
    idle();
    reset_on();
    check("rst_sel", bus.sel, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_addr", bus.addr, 0);
    check("rst_err", bus.err_spurious, 0);
    reset_off();
    check("rst_cmd_ready", bus.cmd_ready, 1);

    // Single write, no stall
    send_cmd(1'b1, 20'h00010, 32'hDEADBEEF);
    step();
    idle();
    check("t1_sel", bus.sel, 1);
    check("t1_rw", bus.RW, 1);
    check("t1_addr", bus.addr, 32'h00010);
    check("t1_din", bus.din, 32'hDEADBEEF);
    step();
    check("t1_sel_off", bus.sel, 0);

    // Stalled write
    send_cmd(1'b1, 20'hABCDE, 32'h0BADF00D);
    step();
    idle();
    bus.bus_stop = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_sel_stall", bus.sel, 1);
      check("t2_addr_stall", bus.addr, 32'hABCDE);
      check("t2_din_stall", bus.din, 32'h0BADF00D);
      check("t2_ready_stall", bus.cmd_ready, 0);
      step();
    end
    bus.bus_stop = 0;
    #1;
    check("t2_ready_accept", bus.cmd_ready, 1);
    check("t2_sel_accept", bus.sel, 1);
    step();
    check("t2_sel_off", bus.sel, 0);

    // Read round trip
    send_cmd(1'b0, 20'h00020, 32'h0);
    step();
    idle();
    check("t3_sel", bus.sel, 1);
    check("t3_rw", bus.RW, 0);
    check("t3_addr", bus.addr, 32'h00020);
    step();
    step();
    bus.pushout = 1; bus.dout = 32'h12345678;
    #1 check("t3_no_writethrough", bus.rsp_valid, 0);
    step();
    idle();
    check("t3_rsp_valid", bus.rsp_valid, 1);
    check("t3_rsp_data", bus.rsp_data, 32'h12345678);
    bus.rsp_ready = 1;
    step();
    idle();
    check("t3_rsp_popped", bus.rsp_valid, 0);

    // Credit limit: five reads, no consumer
    taken = 0; guard = 0;
    while (taken < 5 && guard < 40) begin
      send_cmd(1'b0, 20'h00100 + 20'(taken), $urandom);
      bus.pushout = (m_out > 0); bus.dout = $urandom;
      step();
      if (last_take) taken++;
      guard++;
    end
    check("t4_taken", taken, 5);
    idle();
    for (int i = 0; i < 6; i++) begin
      bus.pushout = (m_out > 0); bus.dout = $urandom;
      step();
    end
    idle();
    #1;
    check("t4_model_fifo", m_q.size(), 4);
    check("t4_sel_blocked", bus.sel, 0);
    check("t4_rsp_valid", bus.rsp_valid, 1);
    bus.rsp_ready = 1;
    step();
    bus.rsp_ready = 0;
    check("t4_sel_after_pop", bus.sel, 1);
    check("t4_addr_fifth", bus.addr, 32'h00104);
    step();
    check("t4_sel_issued", bus.sel, 0);
    bus.pushout = 1; bus.dout = 32'hA5A5_0005;
    step();
    idle();
    bus.rsp_ready = 1;
    repeat (5) step();
    idle();
    check("t4_drained", bus.rsp_valid, 0);

    // Spurious pushout
    bus.pushout = 1; bus.dout = 32'hFFFF0000;
    #1 check("t5_err_before", bus.err_spurious, 0);
    step();
    idle();
    check("t5_err_set", bus.err_spurious, 1);
    check("t5_fifo_unchanged", bus.rsp_valid, 0);
    repeat (3) step();
    check("t5_err_sticky", bus.err_spurious, 1);

    // Reset mid-stall with two queued responses
    taken = 0; guard = 0;
    while ((m_q.size() < 2 || m_out > 0 || m_held) && guard < 30) begin
      if (taken < 2) send_cmd(1'b0, 20'h00300 + 20'(taken), 32'h0);
      else bus.cmd_valid = 0;
      bus.pushout = (m_out > 0); bus.dout = $urandom;
      step();
      if (last_take) taken++;
      guard++;
    end
    idle();
    check("t6_fifo_two", m_q.size(), 2);
    send_cmd(1'b1, 20'h55555, 32'hCAFEF00D);
    step();
    idle();
    bus.bus_stop = 1;
    step();
    check("t6_stalled_sel", bus.sel, 1);
    reset_on();
    check("t6_sel_rst", bus.sel, 0);
    check("t6_rsp_valid_rst", bus.rsp_valid, 0);
    check("t6_rsp_data_rst", bus.rsp_data, 0);
    check("t6_din_rst", bus.din, 0);
    check("t6_err_rst", bus.err_spurious, 0);
    reset_off();
    check("t6_cmd_ready", bus.cmd_ready, 1);
    bus.pushout = 1; bus.dout = 32'h1;
    step();
    idle();
    check("t6_no_outstanding", bus.err_spurious, 1);
    reset_on();
    reset_off();

    // Randomized traffic; pushout only when a read is in flight
    for (int c = 0; c < 2000; c++) begin
      bus.cmd_valid = ($urandom_range(0, 9) < 6);
      bus.cmd_rw    = ($urandom_range(0, 1) == 1);
      bus.cmd_addr  = 20'($urandom);
      bus.cmd_data  = $urandom;
      bus.bus_stop  = ($urandom_range(0, 9) < 3);
      bus.rsp_ready = ($urandom_range(0, 1) == 1);
      bus.pushout   = (m_out > 0) && ($urandom_range(0, 1) == 1);
      bus.dout      = $urandom;
      step();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
